// File: rtl/wb_stage.sv
// Writeback stage: MEM/WB register, load-data formatting, register-file
// write port, forwarding value, retired-instruction counter.
module wb_stage #(
    parameter int XLEN = 32,
    parameter int REGW = 5
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            mem_valid_i,
    input  logic [XLEN-1:0] mem_pc_i,
    input  logic [REGW-1:0] mem_rd_i,
    input  logic            mem_reg_we_i,
    input  logic [1:0]      mem_wb_sel_i,
    input  logic [2:0]      mem_funct3_i,
    input  logic [XLEN-1:0] mem_alu_i,
    input  logic [XLEN-1:0] mem_rdata_i,
    input  logic            stall_i,
    input  logic            flush_i,
    output logic            wb_valid_o,
    output logic [XLEN-1:0] wb_pc_o,
    output logic            reg_we_o,
    output logic [REGW-1:0] reg_wnum_o,
    output logic [XLEN-1:0] reg_wdata_o,
    output logic            misaligned_o,
    output logic [63:0]     instret_o
);

    logic            validQ;
    logic            freshQ;
    logic [XLEN-1:0] pcQ;
    logic [REGW-1:0] rdQ;
    logic            weQ;
    logic [XLEN-1:0] wdataQ;
    logic            misQ;
    logic [63:0]     instretQ;

    logic [1:0]      addrLo;
    logic [7:0]      loadByte;
    logic [15:0]     loadHalf;
    logic [XLEN-1:0] selData;
    logic            selWe;
    logic            selMis;
    logic            retire;

    assign addrLo = mem_alu_i[1:0];
    assign retire = validQ & freshQ;

    always_comb begin
        loadByte = mem_rdata_i[7:0];
        unique case (addrLo)
            2'd0: loadByte = mem_rdata_i[7:0];
            2'd1: loadByte = mem_rdata_i[15:8];
            2'd2: loadByte = mem_rdata_i[23:16];
            2'd3: loadByte = mem_rdata_i[31:24];
        endcase
    end

    assign loadHalf = addrLo[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];

    always_comb begin
        selData = '0;
        selWe   = mem_reg_we_i;
        selMis  = 1'b0;
        unique case (mem_wb_sel_i)
            2'b00: selData = mem_alu_i;
            2'b10: selData = mem_pc_i + XLEN'(4);
            2'b11: selWe = 1'b0;
            2'b01: begin
                unique case (mem_funct3_i)
                    3'b000: selData = {{(XLEN-8){loadByte[7]}}, loadByte};
                    3'b100: selData = {{(XLEN-8){1'b0}}, loadByte};
                    3'b001: begin
                        selMis  = addrLo[0];
                        selData = {{(XLEN-16){loadHalf[15]}}, loadHalf};
                    end
                    3'b101: begin
                        selMis  = addrLo[0];
                        selData = {{(XLEN-16){1'b0}}, loadHalf};
                    end
                    3'b010: begin
                        selMis  = (addrLo != 2'd0);
                        selData = mem_rdata_i;
                    end
                    default: selWe = 1'b0;
                endcase
            end
        endcase
        // a faulting load must never reach the register file
        if (selMis) begin
            selWe   = 1'b0;
            selData = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            validQ   <= 1'b0;
            freshQ   <= 1'b0;
            pcQ      <= '0;
            rdQ      <= '0;
            weQ      <= 1'b0;
            wdataQ   <= '0;
            misQ     <= 1'b0;
            instretQ <= '0;
        end else begin
            if (retire) begin
                instretQ <= instretQ + 64'd1;
            end
            if (flush_i) begin
                validQ <= 1'b0;
                freshQ <= 1'b0;
            end else if (stall_i) begin
                freshQ <= 1'b0;
            end else begin
                validQ <= mem_valid_i;
                freshQ <= mem_valid_i;
                pcQ    <= mem_pc_i;
                rdQ    <= mem_rd_i;
                weQ    <= selWe;
                wdataQ <= selData;
                misQ   <= selMis;
            end
        end
    end

    assign wb_valid_o   = validQ;
    assign wb_pc_o      = pcQ;
    assign reg_we_o     = retire & weQ & (rdQ != '0);
    assign reg_wnum_o   = rdQ;
    assign reg_wdata_o  = wdataQ;
    assign misaligned_o = retire & misQ;
    assign instret_o    = instretQ;

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: directed scenarios plus a random
// run against a behavioural model of the writeback rules.
module tb_wb_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_valid_i;
    logic [31:0] mem_pc_i;
    logic [4:0]  mem_rd_i;
    logic        mem_reg_we_i;
    logic [1:0]  mem_wb_sel_i;
    logic [2:0]  mem_funct3_i;
    logic [31:0] mem_alu_i;
    logic [31:0] mem_rdata_i;
    logic        stall_i;
    logic        flush_i;
    logic        wb_valid_o;
    logic [31:0] wb_pc_o;
    logic        reg_we_o;
    logic [4:0]  reg_wnum_o;
    logic [31:0] reg_wdata_o;
    logic        misaligned_o;
    logic [63:0] instret_o;

    int total = 0;
    int bad = 0;

    // model state
    bit          mValid, mFresh, mWe, mMis;
    bit [31:0]   mPc, mData;
    bit [4:0]    mRd;
    bit [63:0]   mInstret;

    wb_stage dut (
        .clk(clk), .reset(reset),
        .mem_valid_i(mem_valid_i), .mem_pc_i(mem_pc_i),
        .mem_rd_i(mem_rd_i), .mem_reg_we_i(mem_reg_we_i),
        .mem_wb_sel_i(mem_wb_sel_i), .mem_funct3_i(mem_funct3_i),
        .mem_alu_i(mem_alu_i), .mem_rdata_i(mem_rdata_i),
        .stall_i(stall_i), .flush_i(flush_i),
        .wb_valid_o(wb_valid_o), .wb_pc_o(wb_pc_o),
        .reg_we_o(reg_we_o), .reg_wnum_o(reg_wnum_o),
        .reg_wdata_o(reg_wdata_o), .misaligned_o(misaligned_o),
        .instret_o(instret_o)
    );

    always #5 clk = ~clk;

    // reference: value, write enable and fault flag for one instruction
    function automatic void refWb(
        input bit [1:0] sel, input bit [2:0] f3, input bit [31:0] alu,
        input bit [31:0] rdata, input bit [31:0] pc, input bit weIn,
        output bit we, output bit [31:0] data, output bit mis);
        int unsigned a, b, h;
        a = alu % 4;
        we = weIn;
        data = 0;
        mis = 0;
        if (sel == 0) data = alu;
        else if (sel == 2) data = pc + 4;
        else if (sel == 3) we = 0;
        else begin
            b = (rdata >> (8 * a)) % 256;
            h = (rdata >> (16 * (a / 2))) % 65536;
            if (f3 == 0) data = (b >= 128) ? b - 256 : b;
            else if (f3 == 4) data = b;
            else if (f3 == 1 || f3 == 5) begin
                mis = (a % 2) == 1;
                data = (f3 == 1 && h >= 32768) ? h - 65536 : h;
            end else if (f3 == 2) begin
                mis = a != 0;
                data = rdata;
            end else we = 0;
            if (mis) begin
                we = 0;
                data = 0;
            end
        end
    endfunction

    function automatic bit expWe();
        return mValid && mFresh && mWe && (mRd != 0);
    endfunction

    function automatic bit expMis();
        return mValid && mFresh && mMis;
    endfunction

    // one clock: model follows the same posedge the DUT samples
    task automatic step();
        bit w, m;
        bit [31:0] d;
        @(posedge clk);
        if (reset) begin
            {mValid, mFresh, mWe, mMis} = 0;
            mPc = 0; mRd = 0; mData = 0; mInstret = 0;
        end else begin
            if (mValid && mFresh) mInstret = mInstret + 1;
            if (flush_i) begin
                mValid = 0; mFresh = 0;
            end else if (stall_i) begin
                mFresh = 0;
            end else begin
                refWb(mem_wb_sel_i, mem_funct3_i, mem_alu_i, mem_rdata_i,
                      mem_pc_i, mem_reg_we_i, w, d, m);
                mValid = mem_valid_i; mFresh = mem_valid_i;
                mPc = mem_pc_i; mRd = mem_rd_i;
                mWe = w; mData = d; mMis = m;
            end
        end
        #1;
    endtask

    task automatic idle();
        reset = 0; stall_i = 0; flush_i = 0;
        mem_valid_i = 0; mem_pc_i = 0; mem_rd_i = 0; mem_reg_we_i = 0;
        mem_wb_sel_i = 0; mem_funct3_i = 0; mem_alu_i = 0;
        mem_rdata_i = 0;
    endtask

    task automatic drive(input bit [31:0] pc, input bit [4:0] rd,
                         input bit [1:0] sel, input bit [2:0] f3,
                         input bit [31:0] alu, input bit [31:0] rdata);
        idle();
        mem_valid_i = 1; mem_pc_i = pc; mem_rd_i = rd; mem_reg_we_i = 1;
        mem_wb_sel_i = sel; mem_funct3_i = f3; mem_alu_i = alu;
        mem_rdata_i = rdata;
    endtask

    task automatic test_reset();
        idle();
        reset = 1;
        step(); step();
        total++;
        if (wb_valid_o !== 0 || reg_we_o !== 0 || misaligned_o !== 0) begin
            bad++;
            $display("FAIL reset_flags got v=%b we=%b mis=%b want 0 0 0",
                     wb_valid_o, reg_we_o, misaligned_o);
        end
        total++;
        if (wb_pc_o !== 0 || reg_wnum_o !== 0 || reg_wdata_o !== 0) begin
            bad++;
            $display("FAIL reset_data got pc=%h rd=%0d wd=%h want 0",
                     wb_pc_o, reg_wnum_o, reg_wdata_o);
        end
        total++;
        if (instret_o !== 64'd0) begin
            bad++;
            $display("FAIL reset_instret got %0d want 0", instret_o);
        end
        idle();
    endtask

    task automatic test_alu();
        drive(32'h40, 5, 2'b00, 0, 32'h1234_5678, 0);
        step();
        idle();
        total++;
        if (reg_we_o !== 1 || reg_wnum_o !== 5 ||
            reg_wdata_o !== 32'h1234_5678) begin
            bad++;
            $display("FAIL alu_wb got we=%b rd=%0d wd=%h want 1 5 12345678",
                     reg_we_o, reg_wnum_o, reg_wdata_o);
        end
        total++;
        if (instret_o !== 64'd0) begin
            bad++;
            $display("FAIL alu_instret0 got %0d want 0", instret_o);
        end
        step();
        total++;
        if (instret_o !== 64'd1 || reg_we_o !== 0) begin
            bad++;
            $display("FAIL alu_instret1 got %0d we=%b want 1 we=0",
                     instret_o, reg_we_o);
        end
    endtask

    task automatic test_load();
        bit [2:0]  f3s [4] = '{3'b000, 3'b100, 3'b001, 3'b101};
        bit [31:0] as  [4] = '{32'h3, 32'h1, 32'h2, 32'h0};
        bit [31:0] exp [4] = '{32'hFFFF_FF80, 32'h0000_007F,
                               32'hFFFF_80FF, 32'h0000_7F01};
        for (int i = 0; i < 4; i++) begin
            drive(32'h200, 7, 2'b01, f3s[i], as[i], 32'h80FF_7F01);
            step();
            total++;
            if (reg_wdata_o !== exp[i] || reg_we_o !== 1 ||
                misaligned_o !== 0) begin
                bad++;
                $display("FAIL load_%0d got wd=%h we=%b want wd=%h we=1",
                         i, reg_wdata_o, reg_we_o, exp[i]);
            end
        end
        idle();
        step();
    endtask

    task automatic test_misaligned();
        bit [63:0] base;
        base = instret_o;
        drive(32'h300, 9, 2'b01, 3'b010, 32'h1002, 32'hDEAD_BEEF);
        step();
        idle();
        total++;
        if (misaligned_o !== 1 || reg_we_o !== 0) begin
            bad++;
            $display("FAIL mis_lw got mis=%b we=%b want 1 0",
                     misaligned_o, reg_we_o);
        end
        step();
        total++;
        if (misaligned_o !== 0 || instret_o !== base + 1) begin
            bad++;
            $display("FAIL mis_pulse got mis=%b ir=%0d want 0 %0d",
                     misaligned_o, instret_o, base + 1);
        end
        drive(32'h304, 9, 2'b01, 3'b011, 32'h1000, 32'h1);
        step();
        idle();
        total++;
        if (reg_we_o !== 0 || misaligned_o !== 0 || wb_valid_o !== 1) begin
            bad++;
            $display("FAIL illegal_ld got we=%b mis=%b v=%b want 0 0 1",
                     reg_we_o, misaligned_o, wb_valid_o);
        end
        step();
    endtask

    task automatic test_stall();
        bit [63:0] base;
        base = instret_o;
        drive(32'h100, 1, 2'b10, 0, 32'h0, 32'h0);
        step();
        total++;
        if (reg_we_o !== 1 || reg_wdata_o !== 32'h104) begin
            bad++;
            $display("FAIL stall_first got we=%b wd=%h want 1 104",
                     reg_we_o, reg_wdata_o);
        end
        for (int i = 0; i < 3; i++) begin
            idle();
            mem_valid_i = 1; mem_alu_i = 32'hFFFF; mem_rd_i = 3;
            stall_i = 1;
            step();
            total++;
            if (reg_we_o !== 0 || wb_valid_o !== 1 ||
                reg_wdata_o !== 32'h104 || reg_wnum_o !== 1) begin
                bad++;
                $display("FAIL stall_hold%0d got we=%b v=%b wd=%h rd=%0d",
                         i, reg_we_o, wb_valid_o, reg_wdata_o, reg_wnum_o);
            end
        end
        idle();
        step();
        total++;
        if (instret_o !== base + 1) begin
            bad++;
            $display("FAIL stall_count got %0d want %0d", instret_o, base + 1);
        end
    endtask

    task automatic test_priority();
        bit [63:0] base;
        drive(32'h500, 4, 2'b00, 0, 32'h55, 0);
        step();
        drive(32'h504, 6, 2'b00, 0, 32'h66, 0);
        stall_i = 1; flush_i = 1;
        step();
        total++;
        if (wb_valid_o !== 0 || reg_we_o !== 0) begin
            bad++;
            $display("FAIL stall_flush got v=%b we=%b want 0 0",
                     wb_valid_o, reg_we_o);
        end
        drive(32'h508, 6, 2'b00, 0, 32'h77, 0);
        step();
        drive(32'h50C, 8, 2'b00, 0, 32'h88, 0);
        flush_i = 1; reset = 1;
        step();
        idle();
        total++;
        if (wb_valid_o !== 0 || reg_we_o !== 0 || reg_wdata_o !== 0 ||
            wb_pc_o !== 0 || instret_o !== 0 || reg_wnum_o !== 0) begin
            bad++;
            $display("FAIL reset_wins got v=%b we=%b wd=%h pc=%h ir=%0d",
                     wb_valid_o, reg_we_o, reg_wdata_o, wb_pc_o, instret_o);
        end
        base = instret_o;
        drive(32'h600, 0, 2'b00, 0, 32'hABCD, 0);
        step();
        idle();
        total++;
        if (reg_we_o !== 0 || wb_valid_o !== 1) begin
            bad++;
            $display("FAIL rd0_we got we=%b v=%b want 0 1",
                     reg_we_o, wb_valid_o);
        end
        step();
        total++;
        if (instret_o !== base + 1) begin
            bad++;
            $display("FAIL rd0_count got %0d want %0d", instret_o, base + 1);
        end
    endtask

    task automatic test_wrap();
        drive(32'h700, 2, 2'b00, 0, 32'h1, 0);
        step();
        idle();
        force dut.instretQ = 64'hFFFF_FFFF_FFFF_FFFF;
        #1;
        release dut.instretQ;
        mInstret = 64'hFFFF_FFFF_FFFF_FFFF;
        total++;
        if (instret_o !== 64'hFFFF_FFFF_FFFF_FFFF) begin
            bad++;
            $display("FAIL wrap_preset got %h want all ones", instret_o);
        end
        step();
        total++;
        if (instret_o !== 64'd0) begin
            bad++;
            $display("FAIL wrap got %h want 0", instret_o);
        end
    endtask

    task automatic test_random();
        bit [31:0] r;
        for (int i = 0; i < 400; i++) begin
            r = $urandom;
            reset        = ($urandom_range(0, 99) < 2);
            flush_i      = ($urandom_range(0, 99) < 10);
            stall_i      = ($urandom_range(0, 99) < 20);
            mem_valid_i  = ($urandom_range(0, 99) < 80);
            mem_pc_i     = $urandom & 32'hFFFF_FFFC;
            if (r[3:0] == 0) mem_pc_i = 32'hFFFF_FFFC;
            mem_rd_i     = 5'($urandom);
            mem_reg_we_i = r[4];
            mem_wb_sel_i = 2'($urandom);
            mem_funct3_i = 3'($urandom);
            mem_alu_i    = $urandom;
            mem_rdata_i  = $urandom;
            step();
            total++;
            if (wb_valid_o !== mValid || reg_we_o !== expWe() ||
                misaligned_o !== expMis() || instret_o !== mInstret ||
                wb_pc_o !== mPc || reg_wnum_o !== mRd ||
                reg_wdata_o !== mData) begin
                bad++;
                $display("FAIL rand_%0d got v=%b we=%b mis=%b ir=%0d pc=%h rd=%0d wd=%h want v=%b we=%b mis=%b ir=%0d pc=%h rd=%0d wd=%h",
                         i, wb_valid_o, reg_we_o, misaligned_o, instret_o,
                         wb_pc_o, reg_wnum_o, reg_wdata_o, mValid, expWe(),
                         expMis(), mInstret, mPc, mRd, mData);
            end
        end
        idle();
    endtask

    initial begin
        idle();
        reset = 1;
        test_reset();
        test_alu();
        test_load();
        test_misaligned();
        test_stall();
        test_priority();
        test_wrap();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
